// File: rtl/random_delay_timer.sv
// Random delay timer: loads a clamped LFSR value, counts that many ticks, then
// strobes time_out. Optional feature macro: DELAY_ABORT_EN (adds the abort input).
module random_delay_timer #(
  parameter int WIDTH     = 8,
  parameter int MIN_DELAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             tick,
  input  logic [WIDTH-1:0] rnd_in,
`ifdef DELAY_ABORT_EN
  input  logic             abort,
`endif
  output logic             lfsr_en,
  output logic             busy,
  output logic             time_out,
  output logic [WIDTH-1:0] cnt_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_LOAD = WIDTH'(MIN_DELAY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             lfsr_en_q, lfsr_en_d;
  logic             busy_q, busy_d;
  logic             time_out_q, time_out_d;
  logic             abort_req;
  logic [WIDTH-1:0] load_val;

`ifdef DELAY_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Small random values are clamped so every round waits at least MIN_DELAY ticks.
  assign load_val = (rnd_in >= MIN_LOAD) ? rnd_in : MIN_LOAD;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_en_d  = 1'b0;
    time_out_d = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (trigger) begin
          state_d   = COUNT;
          cnt_d     = load_val;
          lfsr_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      COUNT: begin
        busy_d = 1'b1;
        if (abort_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (tick) begin
          // Leaving on the last tick keeps the counter from ever reaching 0 here.
          if (cnt_q == WIDTH'(1)) begin
            state_d    = FIRE;
            cnt_d      = '0;
            time_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
      FIRE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lfsr_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_en_q  <= lfsr_en_d;
      busy_q     <= busy_d;
      time_out_q <= time_out_d;
    end
  end

  assign lfsr_en  = lfsr_en_q;
  assign busy     = busy_q;
  assign time_out = time_out_q;
  assign cnt_out  = cnt_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer: table-driven rounds, hand-written
// corner sequences and a randomized run against a tick-counting reference model.
module tb_random_delay_timer;

  localparam int MIN_DELAY = 4;

  logic       clk;
  logic       rst;
  logic       trigger;
  logic       tick;
  logic       abort;
  logic [7:0] rnd_in;
  logic       lfsr_en;
  logic       busy;
  logic       time_out;
  logic [7:0] cnt_out;

  int testsRun;
  int testsFailed;

  // Reference model: an active wait with a remaining tick count, plus a pending strobe.
  bit m_active;
  bit m_fire;
  bit m_lfsr;
  int m_rem;

  typedef struct {
    logic       trig;
    logic       tk;
    logic [7:0] rnd;
    logic       eLfsr;
    logic       eBusy;
    logic       eTo;
    logic [7:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  random_delay_timer #(.WIDTH(8), .MIN_DELAY(MIN_DELAY)) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .tick     (tick),
    .rnd_in   (rnd_in),
`ifdef DELAY_ABORT_EN
    .abort    (abort),
`endif
    .lfsr_en  (lfsr_en),
    .busy     (busy),
    .time_out (time_out),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic trg, input logic tk, input logic [7:0] rnd,
                           input logic rs, input logic ab);
    bit abEff;
`ifdef DELAY_ABORT_EN
    abEff = ab;
`else
    abEff = 1'b0;
`endif
    m_lfsr = 1'b0;
    if (rs) begin
      m_active = 1'b0;
      m_fire   = 1'b0;
      m_rem    = 0;
    end else if (m_fire) begin
      m_fire = 1'b0;
    end else if (!m_active) begin
      if (trg) begin
        m_active = 1'b1;
        m_rem    = (int'(rnd) >= MIN_DELAY) ? int'(rnd) : MIN_DELAY;
        m_lfsr   = 1'b1;
      end
    end else if (abEff) begin
      m_active = 1'b0;
      m_rem    = 0;
    end else if (tk) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_active = 1'b0;
        m_fire   = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare outputs against the model.
  task automatic applyStimulus(input logic trg, input logic tk, input logic [7:0] rnd,
                               input logic rs, input logic ab);
    trigger = trg;
    tick    = tk;
    rnd_in  = rnd;
    rst     = rs;
    abort   = ab;
    @(posedge clk);
    modelStep(trg, tk, rnd, rs, ab);
    #1;
    checkOutput("mdl_lfsr_en", int'(lfsr_en), int'(m_lfsr));
    checkOutput("mdl_busy", int'(busy), int'(m_active | m_fire));
    checkOutput("mdl_time_out", int'(time_out), int'(m_fire));
    checkOutput("mdl_cnt_out", int'(cnt_out), m_rem);
  endtask

  // One full round with a tick every cycle, expected values written from the latency rule.
  task automatic addRound(input logic [7:0] rnd, input int expL);
    vec_t v;
    v = '{trig: 1'b1, tk: 1'b1, rnd: rnd, eLfsr: 1'b1, eBusy: 1'b1, eTo: 1'b0, eCnt: 8'(expL)};
    vecs.push_back(v);
    for (int k = 1; k < expL; k++) begin
      v = '{trig: 1'b0, tk: 1'b1, rnd: rnd, eLfsr: 1'b0, eBusy: 1'b1, eTo: 1'b0, eCnt: 8'(expL - k)};
      vecs.push_back(v);
    end
    v = '{trig: 1'b0, tk: 1'b1, rnd: rnd, eLfsr: 1'b0, eBusy: 1'b1, eTo: 1'b1, eCnt: 8'd0};
    vecs.push_back(v);
    v = '{trig: 1'b0, tk: 1'b1, rnd: rnd, eLfsr: 1'b0, eBusy: 1'b0, eTo: 1'b0, eCnt: 8'd0};
    vecs.push_back(v);
  endtask

  initial begin
    int lfsrCount;
    int tickCount;
    int fifthTickStep;
    int fireStep;
    bit seen;

    clk = 1'b0;
    rst = 1'b1;
    trigger = 1'b0;
    tick = 1'b0;
    abort = 1'b0;
    rnd_in = 8'd0;
    testsRun = 0;
    testsFailed = 0;
    m_active = 1'b0;
    m_fire = 1'b0;
    m_lfsr = 1'b0;
    m_rem = 0;

    addRound(8'd10, 10);
    addRound(8'd2, 4);
    addRound(8'd0, 4);
    addRound(8'd3, 4);
    addRound(8'd4, 4);
    addRound(8'd5, 5);
    addRound(8'd255, 255);

    // Reset state
    applyStimulus(1'b1, 1'b1, 8'd77, 1'b1, 1'b0);
    checkOutput("reset_lfsr_en", int'(lfsr_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_time_out", int'(time_out), 0);
    checkOutput("reset_cnt_out", int'(cnt_out), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].trig, vecs[i].tk, vecs[i].rnd, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_lfsr_en", i), int'(lfsr_en), int'(vecs[i].eLfsr));
      checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d_time_out", i), int'(time_out), int'(vecs[i].eTo));
      checkOutput($sformatf("vec%0d_cnt_out", i), int'(cnt_out), int'(vecs[i].eCnt));
    end

    // Sparse ticks: first tick 2 cycles into COUNT, then every 4th cycle
    applyStimulus(1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
    checkOutput("sparse_load", int'(cnt_out), 5);
    tickCount = 0;
    fifthTickStep = -1;
    fireStep = -1;
    for (int c = 1; c <= 60; c++) begin
      logic tk;
      tk = (c >= 3) && (((c - 3) % 4) == 0);
      applyStimulus(1'b0, tk, 8'd99, 1'b0, 1'b0);
      if (tk) begin
        tickCount++;
        if (tickCount == 5) fifthTickStep = c;
      end
      if (time_out) begin
        fireStep = c;
        break;
      end
    end
    checkOutput("sparse_ticks_consumed", tickCount, 5);
    checkOutput("sparse_fire_step", fireStep, fifthTickStep);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Trigger noise and rnd changes during COUNT, trigger held through FIRE
    applyStimulus(1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
    lfsrCount = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 3) != 2 || i > 2, 1'b1, 8'(8'd30 + 8'(i)), 1'b0, 1'b0);
      lfsrCount += int'(lfsr_en);
      if (time_out) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("noise_timeout_seen", int'(seen), 1);
    checkOutput("noise_extra_lfsr_en", lfsrCount, 0);
    applyStimulus(1'b1, 1'b1, 8'd20, 1'b0, 1'b0);
    checkOutput("noise_idle_after_fire", int'(busy), 0);
    applyStimulus(1'b1, 1'b1, 8'd20, 1'b0, 1'b0);
    checkOutput("noise_new_round_cnt", int'(cnt_out), 20);
    checkOutput("noise_new_round_lfsr", int'(lfsr_en), 1);

    // Reset mid-count at cnt_out=3
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10 && cnt_out != 8'd3; i++)
      applyStimulus(1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
    checkOutput("rst_mid_precond_cnt", int'(cnt_out), 3);
    applyStimulus(1'b0, 1'b1, 8'd6, 1'b1, 1'b0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_cnt", int'(cnt_out), 0);
    checkOutput("rst_mid_time_out", int'(time_out), 0);
    checkOutput("rst_mid_lfsr_en", int'(lfsr_en), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
      if (time_out || busy) seen = 1'b1;
    end
    checkOutput("rst_mid_stays_idle", int'(seen), 0);

`ifdef DELAY_ABORT_EN
    // Abort together with the final tick
    applyStimulus(1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
    for (int i = 0; i < 20 && cnt_out != 8'd1; i++)
      applyStimulus(1'b0, 1'b1, 8'd8, 1'b0, 1'b0);
    checkOutput("abort_precond_cnt", int'(cnt_out), 1);
    applyStimulus(1'b0, 1'b1, 8'd8, 1'b0, 1'b1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_cnt", int'(cnt_out), 0);
    checkOutput("abort_time_out", int'(time_out), 0);
    applyStimulus(1'b0, 1'b1, 8'd8, 1'b0, 1'b0);
    checkOutput("abort_no_late_fire", int'(time_out), 0);
    applyStimulus(1'b1, 1'b1, 8'd9, 1'b0, 1'b1);
    checkOutput("abort_retrigger_cnt", int'(cnt_out), 9);
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 40));
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), r,
                    ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/random_delay_timer.md
Name: random_delay_timer

Overview:
- Consumes the 8-bit pseudo-random value from the LFSR stage and converts it into a random wait of N ticks. It then emits a single-cycle time_out strobe.
- Sits between the LFSR and the lights/reaction FSM. The FSM triggers the wait; the timer advances the LFSR once per accepted trigger so each round uses a fresh value.

Parameters:
- WIDTH, 8, width of rnd_in and of the internal down-counter.
- MIN_DELAY, 4, lower clamp on the loaded delay in ticks. Legal range 1 to 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- trigger  input  1  start request; sampled only in IDLE.
- tick  input  1  one-cycle timebase strobe from the prescaler; counted only in COUNT.
- rnd_in  input  WIDTH  random value from the LFSR data_out.
- lfsr_en  output  1  one-cycle request to advance the LFSR.
- busy  output  1  high in COUNT and FIRE.
- time_out  output  1  one-cycle strobe when the delay expires.
- cnt_out  output  WIDTH  remaining ticks; 0 in IDLE.

Behaviour:
- Reset:
  - rst=1 at a clock edge forces state IDLE and cnt=0.
  - All outputs are registered and reset to 0: lfsr_en, busy, time_out, cnt_out.
  - Reset mid-count abandons the wait. No time_out is produced.
- States: IDLE, COUNT, FIRE. Encoding is free.
- IDLE, busy=0:
  - trigger=1 at edge E captures load value L into cnt and moves to COUNT.
  - L = rnd_in if rnd_in >= MIN_DELAY, else MIN_DELAY; rnd_in=0 therefore loads MIN_DELAY.
  - lfsr_en=1 for exactly the cycle after E. The LFSR advances once per accepted trigger.
  - A tick in the same cycle as trigger is not counted.
- COUNT, busy=1:
  - Each cycle with tick=1 decrements cnt by 1.
  - tick=1 with cnt==1 moves to FIRE; cnt becomes 0.
  - tick=0 holds cnt.
  - trigger is ignored and rnd_in is not re-sampled.
- FIRE:
  - time_out=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
  - trigger in the FIRE cycle is ignored.
  - A trigger held high is accepted on the first IDLE cycle after FIRE.
- Latency:
  - With a trigger accepted at edge 0 and a tick every cycle, time_out is high in cycle L+1 (edges numbered from the trigger edge).
  - In general, time_out is high the cycle after the L-th counted tick.
- Counter:
  - Unsigned, WIDTH bits. It never underflows: the decrement from 1 exits COUNT, and 0 is unreachable inside COUNT.
  - cnt_out mirrors cnt every cycle.
- Minimum round trip is L+2 cycles. There are no back-to-back strobes closer than that.

Optional Feature:
- Macro: DELAY_ABORT_EN.
- Defined:
  - Adds input port abort, 1 bit.
  - abort=1 in COUNT returns to IDLE next cycle with cnt=0 and no time_out.
  - abort beats tick, including the cnt==1 tick.
  - abort is ignored in IDLE and FIRE.
- Undefined:
  - The port is absent.
  - Only reset or expiry leaves COUNT.

Test Plan:
- rst, rnd_in=10, tick=1 every cycle, trigger pulse at edge 0 -> lfsr_en high in cycle 1 only; cnt_out 10,9,...,1; time_out high only in cycle 11; busy high cycles 1-11; IDLE at cycle 12.
- rnd_in=2 and rnd_in=0 (MIN_DELAY=4), tick every cycle -> cnt_out loads 4 in both cases; time_out in cycle 5.
- rnd_in=5, tick every 4th cycle, first tick 2 cycles after entering COUNT -> exactly 5 ticks consumed; time_out the cycle after the 5th tick; cnt_out holds between ticks.
- trigger pulsed repeatedly during COUNT and held high through FIRE, rnd_in changed mid-count -> count unaffected; single lfsr_en pulse; new round starts in the first IDLE cycle after FIRE using the rnd_in present then.
- rst asserted for one cycle with cnt_out=3 in COUNT -> next cycle all outputs 0, state IDLE, no time_out afterwards until a new trigger.
- DELAY_ABORT_EN defined, rnd_in=8, abort and tick together at cnt_out=1 -> no time_out; busy=0 and cnt_out=0 next cycle; a subsequent trigger behaves normally.
